// File: rtl/coin_pkg.sv
// Shared coin encoding, used by the coin acceptor and the vending machine FSM.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'b00,
    COIN_5    = 2'b01,
    COIN_10   = 2'b10
  } coin_t;

endpackage

// File: rtl/coin_sensor_debounce.sv
// One coin-slot sensor: 2-flop synchroniser, debouncer and coin-width counter.
// 'fall' is high in the cycle before the debounced level drops, so the
// parent can register its accept/reject decision on the same edge.
module coin_sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic sense,
  output logic deb_level,
  output logic fall,
  output logic jammed
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int WW = $clog2(JAM_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WW-1:0] WIDTH_MAX = WW'(JAM_CYCLES);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;
  logic [WW-1:0] width;
  logic          flip;

  // The debounced level toggles on the next edge when this is the last of the
  // required consecutive differing samples.
  assign flip   = (sync_2 != deb_level) && (stable_cnt == CNT_MAX);
  assign fall   = flip && deb_level;
  assign jammed = deb_level && (width == WIDTH_MAX);

  // Two-flop synchroniser for the asynchronous sensor.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      // NOTE: non-blocking keeps sync_2 one cycle behind sync_1; blocking would collapse the chain.
      sync_1 <= sense;
      sync_2 <= sync_1;
    end
  end

  // Debouncer: count consecutive samples that differ from the current level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb_level  <= 1'b0;
      stable_cnt <= '0;
    end else if (sync_2 == deb_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_MAX) begin
      deb_level  <= sync_2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // Width counter: restarts on the debounced rise, saturates at the jam limit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      width <= '0;
    end else if (flip && !deb_level) begin
      width <= '0;
    end else if (deb_level && (width != WIDTH_MAX)) begin
      width <= width + 1'b1;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: two debounced sensors, accept/reject decision,
// accepted-coin FIFO and registered single-cycle coin output.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int JAM_CYCLES      = 256,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sense_5,
  input  logic  sense_10,
  input  logic  ready,
  output coin_t coin,
  output logic  reject,
  output logic  jam,
  output logic  fifo_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

  logic deb_5, fall_5, jammed_5;
  logic deb_10, fall_10, jammed_10;

  // A coin seen while the other sensor was also high is tainted; once the
  // first of the pair is rejected, the second is dropped silently.
  logic coll_5, coll_10;

  coin_t          mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [NW-1:0]  count, count_next;
  logic           push, pop, space, reject_next;
  coin_t          push_code;

  coin_sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_sense_5 (
    .clk       (clk),
    .rst       (rst),
    .sense     (sense_5),
    .deb_level (deb_5),
    .fall      (fall_5),
    .jammed    (jammed_5)
  );

  coin_sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .JAM_CYCLES      (JAM_CYCLES)
  ) u_sense_10 (
    .clk       (clk),
    .rst       (rst),
    .sense     (sense_10),
    .deb_level (deb_10),
    .fall      (fall_10),
    .jammed    (jammed_10)
  );

  assign jam = jammed_5 | jammed_10;

  // Accept/reject decision on a debounced fall; pop frees space before the full check.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    push        = 1'b0;
    push_code   = COIN_NONE;
    reject_next = 1'b0;
    pop         = (count != '0) && ready;
    space       = (count != FULL_COUNT) || pop;
    if (fall_5 && fall_10) begin
      reject_next = 1'b1;
    end else if (fall_5) begin
      if (jammed_5 || deb_10) begin
        reject_next = 1'b1;
      end else if (!coll_5) begin
        push        = space;
        push_code   = COIN_5;
        reject_next = !space;
      end
    end else if (fall_10) begin
      if (jammed_10 || deb_5) begin
        reject_next = 1'b1;
      end else if (!coll_10) begin
        push        = space;
        push_code   = COIN_10;
        reject_next = !space;
      end
    end
    count_next = count + NW'(push) - NW'(pop);
  end

  // Collision taint flags, cleared when their own coin is decided.
  always_ff @(posedge clk) begin
    if (!rst) begin
      coll_5  <= 1'b0;
      coll_10 <= 1'b0;
    end else begin
      coll_5  <= fall_5  ? 1'b0 : (coll_5  | (deb_5 & deb_10));
      coll_10 <= fall_10 ? 1'b0 : (coll_10 | (deb_5 & deb_10));
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the cleared count already marks every entry invalid.
    if (push) mem[wr_ptr] <= push_code;
  end

  // FIFO pointers, count and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      coin      <= COIN_NONE;
      reject    <= 1'b0;
      fifo_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      coin      <= pop ? mem[rd_ptr] : COIN_NONE;
      reject    <= reject_next;
      fifo_full <= (count_next == FULL_COUNT);
    end
  end

endmodule
